lu_serial_sequencer: RTL and testbench

// - Bit-serial driver/collector for the 1-bit OR/NOR logic unit (LU).
// - Latches two WIDTH-bit operands and an op select, presents one bit pair per cycle to the LU (LSB first).
// - Shifts the LU result bit back into a WIDTH-bit result register.
// - Sits directly upstream (drives a/b/select) and downstream (consumes s) of the LU; the LU stays external.

---
 rtl/lu_serial_sequencer_pkg.sv | 19 +
 rtl/lu_serial_sequencer_shift_reg.sv | 44 ++++
 rtl/lu_serial_sequencer.sv | 159 +++++++++++++++
 tb/tb_lu_serial_sequencer.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/lu_serial_sequencer_pkg.sv
// ---------------------------------------------------------------------------
// lu_serial_sequencer_pkg
// Shared definitions for the bit-serial OR/NOR logic-unit sequencer:
//   - lu_state_e : sequencer FSM state encodings (IDLE / SHIFT / DONE)
//   - LU_OP_OR / LU_OP_NOR : op-select codes driven to the LU select input
// No ports (package).
// ---------------------------------------------------------------------------
package lu_serial_sequencer_pkg;

  typedef enum logic [1:0] {
    LU_IDLE  = 2'd0,
    LU_SHIFT = 2'd1,
    LU_DONE  = 2'd2
  } lu_state_e;

  localparam logic LU_OP_OR  = 1'b0;
  localparam logic LU_OP_NOR = 1'b1;

endpackage : lu_serial_sequencer_pkg

// File: rtl/lu_serial_sequencer_shift_reg.sv
// ---------------------------------------------------------------------------
// lu_shift_reg
// WIDTH-bit right-shift register with parallel load and serial input.
// Bit 0 is the serial output (LSB leaves first); the serial input enters
// at the MSB. Load has priority over shift.
// Ports:
//   clk        in   rising-edge clock
//   rst_n      in   asynchronous active-low reset (clears the register)
//   i_load     in   parallel load strobe
//   i_load_val in   WIDTH-bit value loaded when i_load = 1
//   i_shift    in   right-shift strobe
//   i_ser_in   in   bit shifted into the MSB
//   o_q        out  WIDTH-bit register contents
// ---------------------------------------------------------------------------
module lu_shift_reg #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_load_val,
  input  logic             i_shift,
  input  logic             i_ser_in,
  output logic [WIDTH-1:0] o_q
);

  logic [WIDTH-1:0] r_q;

  // Register update: reset, parallel load, right shift, or hold.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_q <= {WIDTH{1'b0}};
    end else if (i_load) begin
      r_q <= i_load_val;
    end else if (i_shift) begin
      r_q <= {i_ser_in, r_q[WIDTH-1:1]};
    end else begin
      r_q <= r_q;
    end
  end

  assign o_q = r_q;

endmodule : lu_shift_reg

// File: rtl/lu_serial_sequencer.sv
// ---------------------------------------------------------------------------
// lu_serial_sequencer
// Bit-serial driver/collector for an external 1-bit OR/NOR logic unit (LU).
// On an accepted start the operands and op select are latched; one bit pair
// per cycle (LSB first) is presented to the LU and the LU result bit is
// shifted back into the result register, so result[i] = LU(op_a[i], op_b[i]).
// Ports:
//   clk      in   rising-edge clock
//   rst_n    in   asynchronous active-low reset
//   start    in   request; sampled only in IDLE or DONE
//   op_a     in   WIDTH-bit operand A, captured on accepted start
//   op_b     in   WIDTH-bit operand B, captured on accepted start
//   op_sel   in   0 = OR, 1 = NOR; captured on accepted start
//   lu_a     out  A shift register bit 0 to LU input a
//   lu_b     out  B shift register bit 0 to LU input b
//   lu_sel   out  latched op select to LU, stable for the whole operation
//   lu_s     in   LU result bit (combinational from lu_a/lu_b/lu_sel)
//   busy     out  high while shifting
//   done     out  one-cycle completion pulse
//   result   out  WIDTH-bit result; valid from done until next accepted start
// ---------------------------------------------------------------------------
module lu_serial_sequencer
  import lu_serial_sequencer_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic             op_sel,
  output logic             lu_a,
  output logic             lu_b,
  output logic             lu_sel,
  input  logic             lu_s,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  lu_state_e        r_state;
  logic [CW-1:0]    r_cnt;
  logic             r_sel;
  logic             r_busy;
  logic             r_done;

  logic             w_accept;
  logic             w_shift;
  logic [WIDTH-1:0] w_a_q;
  logic [WIDTH-1:0] w_b_q;
  logic [WIDTH-1:0] w_res_q;
  logic             w_unused;

  // Start is only honoured between operations; while shifting it is ignored.
  assign w_accept = ((r_state == LU_IDLE) || (r_state == LU_DONE)) && start;
  assign w_shift  = (r_state == LU_SHIFT);

  // FSM, bit counter, latched op select and registered status outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= LU_IDLE;
      r_cnt   <= {CW{1'b0}};
      r_sel   <= LU_OP_OR;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      case (r_state)
        LU_IDLE, LU_DONE: begin
          if (start) begin
            r_state <= LU_SHIFT;
            r_cnt   <= {CW{1'b0}};
            r_sel   <= op_sel;
            r_busy  <= 1'b1;
            r_done  <= 1'b0;
          end else begin
            r_state <= LU_IDLE;
            r_cnt   <= r_cnt;
            r_sel   <= r_sel;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
          end
        end
        LU_SHIFT: begin
          // The last bit is consumed on the edge where cnt = WIDTH-1; the
          // counter holds there instead of wrapping.
          if (r_cnt == CNT_LAST) begin
            r_state <= LU_DONE;
            r_cnt   <= r_cnt;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end else begin
            r_state <= LU_SHIFT;
            r_cnt   <= r_cnt + CNT_ONE;
            r_busy  <= 1'b1;
            r_done  <= 1'b0;
          end
          r_sel <= r_sel;
        end
        default: begin
          r_state <= LU_IDLE;
          r_cnt   <= {CW{1'b0}};
          r_sel   <= LU_OP_OR;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
        end
      endcase
    end
  end

  // Operand A: loaded on start, shifted right with zero fill while shifting.
  lu_shift_reg #(.WIDTH(WIDTH)) u_sr_a (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_load     (w_accept),
    .i_load_val (op_a),
    .i_shift    (w_shift),
    .i_ser_in   (1'b0),
    .o_q        (w_a_q)
  );

  // Operand B: same behaviour as A.
  lu_shift_reg #(.WIDTH(WIDTH)) u_sr_b (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_load     (w_accept),
    .i_load_val (op_b),
    .i_shift    (w_shift),
    .i_ser_in   (1'b0),
    .o_q        (w_b_q)
  );

  // Result: cleared on start, LU bit enters at the MSB so that after WIDTH
  // shifts the first (LSB) result bit has arrived at bit 0.
  lu_shift_reg #(.WIDTH(WIDTH)) u_sr_res (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_load     (w_accept),
    .i_load_val ({WIDTH{1'b0}}),
    .i_shift    (w_shift),
    .i_ser_in   (lu_s),
    .o_q        (w_res_q)
  );

  // Only bit 0 of each operand register feeds the LU.
  assign w_unused = ^{w_a_q[WIDTH-1:1], w_b_q[WIDTH-1:1]};

  assign lu_a   = w_a_q[0];
  assign lu_b   = w_b_q[0];
  assign lu_sel = r_sel;
  assign busy   = r_busy;
  assign done   = r_done;
  assign result = w_res_q;

endmodule : lu_serial_sequencer

// File: tb/tb_lu_serial_sequencer.sv
// ---------------------------------------------------------------------------
// tb_lu_serial_sequencer
// Directed bench: sequencer plus a behavioural OR/NOR LU in the loop.
// Inputs are driven on the falling edge, outputs sampled on the falling edge.
// ---------------------------------------------------------------------------
module tb_lu_serial_sequencer;

  localparam int W = 8;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic [W-1:0] op_a;
  logic [W-1:0] op_b;
  logic         op_sel;
  logic         lu_a;
  logic         lu_b;
  logic         lu_sel;
  logic         lu_s;
  logic         busy;
  logic         done;
  logic [W-1:0] result;

  int checks = 0;
  int errors = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // External 1-bit LU: 0 = OR, 1 = NOR.
  assign lu_s = lu_sel ? ~(lu_a | lu_b) : (lu_a | lu_b);

  lu_serial_sequencer #(.WIDTH(W)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .op_a   (op_a),
    .op_b   (op_b),
    .op_sel (op_sel),
    .lu_a   (lu_a),
    .lu_b   (lu_b),
    .lu_sel (lu_sel),
    .lu_s   (lu_s),
    .busy   (busy),
    .done   (done),
    .result (result)
  );

  // Drive a one-cycle start; returns at the falling edge after the start edge.
  task automatic launch(input logic [W-1:0] a, input logic [W-1:0] b, input logic sel);
    @(negedge clk);
    op_a   = a;
    op_b   = b;
    op_sel = sel;
    start  = 1'b1;
    @(negedge clk);
    start  = 1'b0;
  endtask

  // Full operation: expects exactly W busy cycles with stable lu_sel, then done.
  // Returns at the falling edge in the DONE cycle.
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic sel,
                        input logic [W-1:0] exp, input string name);
    int busy_cnt;
    int sel_bad;
    busy_cnt = 0;
    sel_bad  = 0;
    launch(a, b, sel);
    for (int i = 0; i < W; i++) begin
      if (busy === 1'b1) busy_cnt++;
      if (lu_sel !== sel) sel_bad++;
      if (i < W - 1) @(negedge clk);
    end
    checks++;
    if (busy_cnt != W) begin
      errors++;
      $display("FAIL %s_busy_cycles got %0d exp %0d", name, busy_cnt, W);
    end
    checks++;
    if (sel_bad != 0) begin
      errors++;
      $display("FAIL %s_lu_sel_stable got %0d bad cycles exp 0", name, sel_bad);
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL %s_done got done=%b busy=%b exp done=1 busy=0", name, done, busy);
    end
    checks++;
    if (result !== exp) begin
      errors++;
      $display("FAIL %s_result got %h exp %h", name, result, exp);
    end
  endtask

  task automatic test_reset();
    rst_n  = 1'b0;
    start  = 1'b0;
    op_a   = 8'h00;
    op_b   = 8'h00;
    op_sel = 1'b0;
    #12;
    checks++;
    if ({busy, done, lu_a, lu_b, lu_sel} !== 5'b00000 || result !== 8'h00) begin
      errors++;
      $display("FAIL reset_state got busy=%b done=%b lu=%b%b%b result=%h exp all 0",
               busy, done, lu_a, lu_b, lu_sel, result);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL reset_idle got busy=%b done=%b exp 0 0", busy, done);
    end
  endtask

  task automatic test_or();
    run_op(8'hA5, 8'h0F, 1'b0, 8'hAF, "or");
    @(negedge clk);
    checks++;
    if (done !== 1'b0) begin
      errors++;
      $display("FAIL or_done_one_cycle got %b exp 0", done);
    end
    repeat (3) @(negedge clk);
    checks++;
    if (result !== 8'hAF || busy !== 1'b0) begin
      errors++;
      $display("FAIL or_idle_hold got result=%h busy=%b exp AF 0", result, busy);
    end
  endtask

  task automatic test_nor();
    run_op(8'hA5, 8'h0F, 1'b1, 8'h50, "nor");
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    run_op(8'h3C, 8'h01, 1'b1, 8'hC2, "b2b_first");
    // Still in the DONE cycle: request the next op immediately.
    op_a   = 8'hFF;
    op_b   = 8'h00;
    op_sel = 1'b1;
    start  = 1'b1;
    @(negedge clk);
    start  = 1'b0;
    checks++;
    if (busy !== 1'b1 || done !== 1'b0 || result !== 8'h00 || lu_a !== 1'b1) begin
      errors++;
      $display("FAIL b2b_no_bubble got busy=%b done=%b result=%h lu_a=%b exp 1 0 00 1",
               busy, done, result, lu_a);
    end
    repeat (W - 1) @(negedge clk);
    @(negedge clk);
    checks++;
    if (done !== 1'b1 || result !== 8'h00) begin
      errors++;
      $display("FAIL b2b_second got done=%b result=%h exp 1 00", done, result);
    end
    @(negedge clk);
  endtask

  task automatic test_ignore_busy();
    int done_cnt;
    int done_at;
    int sel_bad;
    logic [W-1:0] res_at_done;
    done_cnt    = 0;
    done_at     = -1;
    sel_bad     = 0;
    res_at_done = 8'h00;
    launch(8'hA5, 8'h0F, 1'b0);
    // Falling edge k is after start edge + (k-1); done expected at k = W+1.
    for (int k = 1; k <= W + 6; k++) begin
      if (k == 3) begin
        op_a   = 8'h33;
        op_b   = 8'hCC;
        op_sel = 1'b1;
        start  = 1'b1;
      end else begin
        start  = 1'b0;
      end
      if (busy === 1'b1 && lu_sel !== 1'b0) sel_bad++;
      if (done === 1'b1) begin
        done_cnt++;
        done_at     = k;
        res_at_done = result;
      end
      @(negedge clk);
    end
    checks++;
    if (done_cnt != 1 || done_at != W + 1) begin
      errors++;
      $display("FAIL ignore_done_pulse got count=%0d at=%0d exp 1 at %0d", done_cnt, done_at, W + 1);
    end
    checks++;
    if (res_at_done !== 8'hAF || sel_bad != 0) begin
      errors++;
      $display("FAIL ignore_result got %h sel_bad=%0d exp AF 0", res_at_done, sel_bad);
    end
  endtask

  task automatic test_abort();
    int bad;
    bad = 0;
    launch(8'hFF, 8'h00, 1'b0);
    repeat (3) @(negedge clk);
    // Three bits shifted in so far: result is non-zero before the abort.
    checks++;
    if (busy !== 1'b1 || result !== 8'hE0 || lu_a !== 1'b1) begin
      errors++;
      $display("FAIL abort_pre got busy=%b result=%h lu_a=%b exp 1 E0 1", busy, result, lu_a);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if ({busy, done, lu_a, lu_b, lu_sel} !== 5'b00000 || result !== 8'h00) begin
      errors++;
      $display("FAIL abort_reset got busy=%b done=%b lu=%b%b%b result=%h exp all 0",
               busy, done, lu_a, lu_b, lu_sel, result);
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (done !== 1'b0 || busy !== 1'b0 || result !== 8'h00) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL abort_stays_idle got %0d bad cycles exp 0", bad);
    end
  endtask

  initial begin
    test_reset();
    test_or();
    test_nor();
    test_back_to_back();
    test_ignore_busy();
    test_abort();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_lu_serial_sequencer
